// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the start-class predicate.
package md_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MD_OP_W         = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // True for ops that occupy the unit for multiple cycles.
    function automatic logic is_md_start(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply and divide datapath producing the HI/LO pair.
// Signed divide works on magnitudes so MIN_INT / -1 wraps cleanly.
module md_calc
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [XLEN-1:0]    b_i,
    output logic [XLEN-1:0]    hi_o,
    output logic [XLEN-1:0]    lo_o,
    output logic               div_by_zero_o
);

    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        hi_o          = '0;
        lo_o          = '0;
        div_by_zero_o = 1'b0;
        is_signed     = (op_i == MD_MULT) || (op_i == MD_DIV);

        // Sign-extend for signed ops; the low 64 bits of the product are exact.
        a_ext = is_signed ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
        b_ext = is_signed ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
        prod  = a_ext * b_ext;

        a_neg   = is_signed && a_i[XLEN-1];
        b_neg   = is_signed && b_i[XLEN-1];
        a_mag   = a_neg ? XLEN'(-a_i) : a_i;
        b_mag   = b_neg ? XLEN'(-b_i) : b_i;
        divisor = (b_i == '0) ? XLEN'(1) : b_mag;
        quot    = a_mag / divisor;
        rem     = a_mag % divisor;

        case (op_i)
            MD_MULT, MD_MULTU: begin
                hi_o = prod[2*XLEN-1:XLEN];
                lo_o = prod[XLEN-1:0];
            end
            MD_DIV, MD_DIVU: begin
                lo_o          = (a_neg ^ b_neg) ? XLEN'(-quot) : quot;
                hi_o          = a_neg ? XLEN'(-rem) : rem;
                div_by_zero_o = (b_i == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div with a
// shadow result, and gates all HI/LO side effects on the exception request.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Req,
    input  logic [MD_OP_W-1:0] MDOp,
    input  logic [XLEN-1:0]    A,
    input  logic [XLEN-1:0]    B,
    output logic               Start,
    output logic               Busy,
    output logic [XLEN-1:0]    HI,
    output logic [XLEN-1:0]    LO,
    output logic [XLEN-1:0]    MDOut
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  shadow_hi_q, shadow_hi_d;
    logic [XLEN-1:0]  shadow_lo_q, shadow_lo_d;
    logic             dbz_q, dbz_d;

    logic [XLEN-1:0]  calc_hi;
    logic [XLEN-1:0]  calc_lo;
    logic             calc_dbz;
    logic             is_mult;

    md_calc u_calc (
        .op_i          (MDOp),
        .a_i           (A),
        .b_i           (B),
        .hi_o          (calc_hi),
        .lo_o          (calc_lo),
        .div_by_zero_o (calc_dbz)
    );

    // Hazard-visible start is not gated by Req to keep it off the CP0 path.
    assign Start   = is_md_start(MDOp);
    assign is_mult = (MDOp == MD_MULT) || (MDOp == MD_MULTU);

    always_comb begin
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        dbz_d       = dbz_q;

        if (cnt_q != '0) begin
            // In-flight op belongs to an older instruction, so Req never cancels it.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                if (!dbz_q) begin
                    hi_d = shadow_hi_q;
                    lo_d = shadow_lo_q;
                end
            end
        end else if (!Req && !busy_q) begin
            if (Start) begin
                shadow_hi_d = calc_hi;
                shadow_lo_d = calc_lo;
                dbz_d       = calc_dbz;
                cnt_d       = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                busy_d      = 1'b1;
            end else if (MDOp == MD_MTHI) begin
                hi_d = A;
            end else if (MDOp == MD_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            dbz_q       <= dbz_d;
        end
    end

    assign Busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = (MDOp == MD_MFHI) ? hi_q :
                   (MDOp == MD_MFLO) ? lo_q : '0;

    // The hazard unit must never present a start or move-to while busy.
    a_no_issue_while_busy : assert property (@(posedge clk) disable iff (!reset)
        !(busy_q && (Start || (MDOp == MD_MTHI) || (MDOp == MD_MTLO))))
        else $error("md_unit: md op issued while Busy");

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency, and mthi/mtlo/mfhi/mflo.
- Owns the HI/LO architectural registers.
- Drives Start and Busy to the hazard unit, which stalls md-class instructions in D while either is high.
- An exception request (Req) from CP0 suppresses any E-stage HI/LO side effect so that precise exceptions hold.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, Busy duration in cycles for div/divu.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- Req  input  1  exception/interrupt taken this cycle; E-stage md instruction is flushed.
- MDOp  input  4  E-stage op: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- A  input  32  forwarded rs value, E stage.
- B  input  32  forwarded rt value, E stage.
- Start  output  1  combinational; high when MDOp is MULT/MULTU/DIV/DIVU.
- Busy  output  1  registered; operation in flight.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- MDOut  output  32  HI when MDOp=MFHI, LO when MDOp=MFLO, else 0.

Behaviour:
- Reset (async, reset=0):
  - Busy=0, HI=0, LO=0, cnt=0, shadow result=0.
  - An in-flight operation is abandoned and no HI/LO update follows.
- Start is purely combinational from MDOp; it is not gated by Req, so the hazard view stays timing-clean.
- Accept rule at a rising edge: MDOp is mult/div class, Req=0, Busy=0.
  - Compute the 64-bit result from the A/B values present at that edge and hold it in shadow_hi/shadow_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; Busy=1 from the next cycle.
- Countdown: while cnt>0, cnt decrements each edge.
  - On the edge where cnt goes 1->0, HI/LO take the shadow values and Busy falls on that same edge.
  - A mult accepted at edge t gives Busy high for cycles t+1..t+5; HI/LO are new from cycle t+6 (visible to an mfhi in E then).
- Arithmetic:
  - MULT: signed 32x32->64, with HI=upper and LO=lower.
  - MULTU: unsigned 32x32->64.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): Busy still runs the full DIV_CYCLES; HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - With Req=0 and Busy=0, HI (or LO) takes A at the edge; Busy is unaffected.
  - With Req=1 there is no write.
- MFHI/MFLO: MDOut is combinational from the current HI/LO, with no side effect.
- Req=1 at an edge: no accept and no mt write. An operation already in flight continues and completes normally, because it belongs to an older committed instruction.
- Start or MTHI/MTLO while Busy=1 is a hazard-unit violation: ignore it, leave state unchanged, and flag it with a simulation-only assertion.
- Only one operation is ever in flight; there is no queueing.

Decomposition:
- Shared package md_pkg:
  - MDOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Default MULT_CYCLES/DIV_CYCLES constants.
  - Helper predicate is_md_start(op).
- Sub-module md_calc: combinational; inputs op, A, B; outputs hi, lo, div_by_zero.
- md_unit keeps the counter, Busy, shadow and architectural registers, and the Req gating.

Test Plan:
1. Reset low mid-DIV (cnt=4) -> Busy=0, HI=LO=0 immediately; after release, HI/LO stay 0 through 10 further cycles.
2. MULT A=0xFFFFFFFE (-2), B=3, Req=0 at edge t -> Busy=1 for cycles t+1..t+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI -> MDOut=0xFFFFFFFF.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
4. DIVU B=0 with HI=0x11, LO=0x22 preset -> Busy high for 10 cycles; HI=0x11, LO=0x22 unchanged.
5. MULTU with Req=1 at the accept edge -> Start=1 that cycle, Busy stays 0, HI/LO unchanged. MTLO A=0x5A with Req=1 -> LO unchanged; same with Req=0 -> LO=0x5A next cycle.
6. MULT in flight, Req pulses at cycle 3 of Busy -> operation still completes at cycle 5 with the correct HI/LO.
